// File: rtl/tmds_encoder.sv
// Three-channel DVI 1.0 TMDS encoder: transition minimisation then DC balance,
// two register stages, one symbol per channel per pixel clock.
module tmds_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [9:0] tmds_r,
  output logic [9:0] tmds_g,
  output logic [9:0] tmds_b
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = CTRL_00;
      2'b01:   sym = CTRL_01;
      2'b10:   sym = CTRL_10;
      default: sym = CTRL_11;
    endcase
    return sym;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    use_xnor = (n > 4'd4) || (n == 4'd4 && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int unsigned i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Returns {next cnt, symbol}; disparity math is done one bit wider than cnt.
  function automatic logic [14:0] dc_balance(input logic [8:0] qm,
                                             input logic signed [4:0] cnt);
    logic [3:0]        n1;
    logic signed [5:0] disp;
    logic signed [5:0] acc;
    logic signed [5:0] nxt;
    logic [9:0]        sym;
    n1 = '0;
    for (int unsigned i = 0; i < 8; i++) n1 = n1 + {3'b000, qm[i]};
    disp = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    acc  = {cnt[4], cnt};
    if (cnt == 5'sd0 || disp == 6'sd0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? (acc + disp) : (acc - disp);
    end else if ((acc > 6'sd0 && disp > 6'sd0) || (acc < 6'sd0 && disp < 6'sd0)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nxt = acc - disp + (qm[8] ? 6'sd2 : 6'sd0);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nxt = acc + disp - (qm[8] ? 6'sd0 : 6'sd2);
    end
    return {5'(nxt), sym};
  endfunction

  logic              de_q;
  logic [1:0]        ctrl_q;
  logic [8:0]        qm_r, qm_g, qm_b;
  logic signed [4:0] cnt_r, cnt_g, cnt_b;
  logic signed [4:0] cnt_r_nxt, cnt_g_nxt, cnt_b_nxt;
  logic [9:0]        sym_r, sym_g, sym_b;

  always_comb begin
    {cnt_r_nxt, sym_r} = dc_balance(qm_r, cnt_r);
    {cnt_g_nxt, sym_g} = dc_balance(qm_g, cnt_g);
    {cnt_b_nxt, sym_b} = dc_balance(qm_b, cnt_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q   <= 1'b0;
      ctrl_q <= '0;
      qm_r   <= '0;
      qm_g   <= '0;
      qm_b   <= '0;
      cnt_r  <= '0;
      cnt_g  <= '0;
      cnt_b  <= '0;
      tmds_r <= CTRL_00;
      tmds_g <= CTRL_00;
      tmds_b <= CTRL_00;
    end else begin
      de_q   <= de;
      ctrl_q <= {vsync, hsync};
      qm_r   <= min_trans(r);
      qm_g   <= min_trans(g);
      qm_b   <= min_trans(b);
      // Blanking clears disparity so the next active pixel starts balanced.
      if (!de_q) begin
        tmds_r <= CTRL_00;
        tmds_g <= CTRL_00;
        tmds_b <= ctrl_symbol(ctrl_q);
        cnt_r  <= '0;
        cnt_g  <= '0;
        cnt_b  <= '0;
      end else begin
        tmds_r <= sym_r;
        tmds_g <= sym_g;
        tmds_b <= sym_b;
        cnt_r  <= cnt_r_nxt;
        cnt_g  <= cnt_g_nxt;
        cnt_b  <= cnt_b_nxt;
      end
    end
  end

endmodule
